// File: rtl/alu_md.sv
// Execute-stage ALU with a registered result, plus an iterative
// multiply/divide engine that owns the HI/LO registers.
module alu_md #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             arith_op,
  input  logic [2:0]       op,
  input  logic             slt_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             overflow,
  output logic             out_valid,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_t;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   amt;
  logic             lt_s;

  // Integer ALU: arithmetic/logic/shift result and signed overflow
  always_comb begin
    sum     = a + b;
    diff    = {1'b0, a} - {1'b0, b};
    lt_s    = $signed(a) < $signed(b);
    amt     = op[2] ? b[SHW-1:0] : shamt;
    alu_res = '0;
    alu_ovf = 1'b0;
    if (arith_op) begin
      if (op[2]) begin
        case (op[1:0])
          2'b00:   alu_res = a & b;
          2'b01:   alu_res = a | b;
          2'b10:   alu_res = a ^ b;
          default: alu_res = ~(a | b);
        endcase
      end else if (!op[1]) begin
        alu_res = sum;
        alu_ovf = !op[0] && (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end else if (slt_op) begin
        alu_res = WIDTH'(op[0] ? diff[WIDTH] : lt_s);
      end else begin
        alu_res = diff[WIDTH-1:0];
        alu_ovf = !op[0] && (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
    end else begin
      case (op[1:0])
        2'b00:   alu_res = a << amt;
        2'b01:   alu_res = a >> amt;
        2'b11:   alu_res = WIDTH'($signed(a) >>> amt);
        default: alu_res = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y         <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y        <= alu_res;
        zero     <= (alu_res == '0);
        overflow <= alu_ovf;
      end
    end
  end

  md_state_t        state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             is_mul_q, is_mul_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             busy_d, done_d;

  logic             sgn;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   madd, shl, dsub;
  logic [2*WIDTH-1:0] prod;

  // Datapath helpers: operand magnitudes, one multiply/divide step, final product
  always_comb begin
    sgn   = !md_op[0];
    mag_a = (sgn && a[WIDTH-1]) ? -a : a;
    mag_b = (sgn && b[WIDTH-1]) ? -b : b;
    madd  = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : '0);
    shl   = {rem_q, quo_q[WIDTH-1]};
    dsub  = shl - {1'b0, dvs_q};
    prod  = neg_lo_q ? -{rem_q, quo_q} : {rem_q, quo_q};
  end

  // Mul/div control: next state and next register values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    is_mul_d = is_mul_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi;
    lo_d     = lo;
    case (state_q)
      IDLE: begin
        if (md_start && !md_busy) begin
          state_d  = CALC;
          cnt_d    = '0;
          rem_d    = '0;
          is_mul_d = !md_op[1];
          neg_hi_d = 1'b0;
          if (!md_op[1]) begin
            dvs_d    = mag_a;
            quo_d    = mag_b;
            neg_lo_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
          end else if (b == '0) begin
            // Divide by zero runs unsigned on raw a: quotient all ones, remainder a
            dvs_d    = '0;
            quo_d    = a;
            neg_lo_d = 1'b0;
          end else begin
            dvs_d    = mag_b;
            quo_d    = mag_a;
            neg_lo_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi_d = sgn && a[WIDTH-1];
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) state_d = FIX;
        if (is_mul_q) begin
          rem_d = madd[WIDTH:1];
          quo_d = {madd[0], quo_q[WIDTH-1:1]};
        end else if (!dsub[WIDTH]) begin
          rem_d = dsub[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shl[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
      end
      FIX: begin
        state_d = IDLE;
        if (is_mul_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          hi_d = neg_hi_q ? -rem_q : rem_q;
          lo_d = neg_lo_q ? -quo_q : quo_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // Busy covers the FIX cycle's result visibility before release
    busy_d = (state_d != IDLE) || (state_q == FIX);
    done_d = (state_q == FIX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      is_mul_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      md_busy  <= 1'b0;
      md_done  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      is_mul_q <= is_mul_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi       <= hi_d;
      lo       <= lo_d;
      md_busy  <= busy_d;
      md_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md: table-driven ALU vectors plus mul/div
// latency, busy-ignore and mid-operation reset sequences.
module tb_alu_md;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, arith_op, slt_op, md_start;
  logic [2:0]  op;
  logic [1:0]  md_op;
  logic [31:0] a, b, y, hi, lo;
  logic [4:0]  shamt;
  logic        zero, overflow, out_valid, md_busy, md_done;

  int total = 0;
  int passed = 0;

  alu_md #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .arith_op(arith_op),
    .op(op), .slt_op(slt_op), .a(a), .b(b), .shamt(shamt),
    .y(y), .zero(zero), .overflow(overflow), .out_valid(out_valid),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .md_done(md_done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ar;
    logic [2:0]  op;
    logic        slt;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] ey;
    logic        ez;
    logic        eo;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  // Run one mul/div; optionally pulse md_start again after glitch_at cycles
  task automatic md_run(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                        input logic [31:0] eh, input logic [31:0] el, input int glitch_at,
                        input string nm);
    int done_at;
    @(negedge clk);
    md_start = 1'b1; md_op = mop; a = ma; b = mb;
    @(posedge clk); #1;
    chk({nm, " busy_after_start"}, 64'(md_busy), 64'd1);
    md_start = 1'b0;
    done_at = 0;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      @(posedge clk); #1;
      if (md_done) done_at = k;
      md_start = (k == glitch_at);
      if (k == glitch_at) begin
        md_op = 2'b10; a = 32'd1000; b = 32'd3;
      end
    end
    chk({nm, " done_latency"}, 64'(done_at), 64'd33);
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
    chk({nm, " busy_in_done"}, 64'(md_busy), 64'd1);
    @(posedge clk); #1;
    chk({nm, " released"}, {62'd0, md_busy, md_done}, 64'd0);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; in_valid = 1'b0; arith_op = 1'b0; slt_op = 1'b0; md_start = 1'b0;
    op = 3'b000; md_op = 2'b00; a = '0; b = '0; shamt = '0;

    vecs[0]  = '{1'b1, 3'b000, 1'b0, 32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 3'b001, 1'b0, 32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 3'b010, 1'b1, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        1'b0, 1'b0};
    vecs[3]  = '{1'b1, 3'b011, 1'b1, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b1, 1'b0};
    vecs[4]  = '{1'b1, 3'b010, 1'b0, 32'd5,        32'd5,        5'd0,  32'h0,        1'b1, 1'b0};
    vecs[5]  = '{1'b1, 3'b010, 1'b0, 32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 3'b101, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 3'b110, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 3'b111, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h000F000F, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'b011, 1'b0, 32'h80000000, 32'h0,        5'd4,  32'hF8000000, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 3'b101, 1'b0, 32'h80000000, 32'd36,       5'd0,  32'h08000000, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 3'b000, 1'b0, 32'h1,        32'h0,        5'd31, 32'h80000000, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 3'b010, 1'b0, 32'hFFFFFFFF, 32'h0,        5'd3,  32'h0,        1'b1, 1'b0};
    vecs[14] = '{1'b0, 3'b001, 1'b0, 32'h80000000, 32'h0,        5'd4,  32'h08000000, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset y", 64'(y), 64'd0);
    chk("reset flags", {59'd0, zero, overflow, out_valid, md_busy, md_done}, 64'h10);
    chk("reset hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      in_valid = 1'b1; arith_op = vecs[i].ar; op = vecs[i].op; slt_op = vecs[i].slt;
      a = vecs[i].a; b = vecs[i].b; shamt = vecs[i].sh;
      @(posedge clk); #1;
      chk($sformatf("alu[%0d] y", i), 64'(y), 64'(vecs[i].ey));
      chk($sformatf("alu[%0d] zero", i), 64'(zero), 64'(vecs[i].ez));
      chk($sformatf("alu[%0d] ovf", i), 64'(overflow), 64'(vecs[i].eo));
      chk($sformatf("alu[%0d] out_valid", i), 64'(out_valid), 64'd1);
    end

    @(negedge clk);
    in_valid = 1'b0; arith_op = 1'b1; op = 3'b000; a = 32'd1; b = 32'd2;
    @(posedge clk); #1;
    chk("hold out_valid", 64'(out_valid), 64'd0);
    chk("hold y", 64'(y), 64'h08000000);
    chk("hold zero", 64'(zero), 64'd0);

    md_run(2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0, "MULT -3*7");
    md_run(2'b01, 32'hFFFFFFFF, 32'd2,        32'h1,        32'hFFFFFFFE, 0, "MULTU");
    md_run(2'b00, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0,        32'd15,       0, "MULT -3*-5");
    md_run(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, "DIV -7/2");
    md_run(2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 0, "DIV 7/-2");
    md_run(2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 0, "DIVU 100/0");
    md_run(2'b10, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 0, "DIV -8/0");
    md_run(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       0, "DIVU 100/7");
    md_run(2'b01, 32'hFFFFFFFF, 32'd2,        32'h1,        32'hFFFFFFFE, 5, "busy ignore");

    // Reset mid-CALC, with a start request during reset that must be ignored
    @(negedge clk);
    md_start = 1'b1; md_op = 2'b10; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    md_start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; md_start = 1'b1; md_op = 2'b00;
    @(posedge clk); #1;
    chk("midreset busy/done", {62'd0, md_busy, md_done}, 64'd0);
    chk("midreset hilo", {hi, lo}, 64'd0);
    chk("midreset alu", {31'd0, zero, y}, 64'h1_00000000);
    @(negedge clk);
    rst_n = 1'b1; md_start = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (md_done || md_busy || hi != 32'd0 || lo != 32'd0) bad++;
    end
    chk("no done after reset", 64'(bad), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
